// File: rtl/portas_logicas_pkg.sv
// portas_logicas_pkg: shared constants for the registered logic-gate bank
package portas_logicas_pkg;
  localparam int WIDTH_DEF = 3;
endpackage

// File: rtl/portas_logicas_core.sv
// portas_logicas_core: purely combinational bitwise gates and equality flag
module portas_logicas_core
  import portas_logicas_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic [WIDTH-1:0] s4,
  output logic [WIDTH-1:0] s5,
  output logic [WIDTH-1:0] s6,
  output logic [WIDTH-1:0] s7,
  output logic             s8
);
  assign s1 = a & b;
  assign s2 = a | b;
  assign s3 = ~(a & b);
  assign s4 = ~(a | b);
  assign s5 = a ^ b;
  assign s6 = ~(a ^ b);
  assign s7 = ~a;
  assign s8 = (a == b);
endmodule

// File: rtl/portas_logicas.sv
// portas_logicas: gate core followed by an enabled, async-reset output register bank
module portas_logicas
  import portas_logicas_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic [WIDTH-1:0] s4,
  output logic [WIDTH-1:0] s5,
  output logic [WIDTH-1:0] s6,
  output logic [WIDTH-1:0] s7,
  output logic             s8
);
  logic [WIDTH-1:0] s1_d, s2_d, s3_d, s4_d, s5_d, s6_d, s7_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q, s4_q, s5_q, s6_q, s7_q;
  logic             s8_d, s8_q;

  portas_logicas_core #(.WIDTH(WIDTH)) u_core (
    .a (a),
    .b (b),
    .s1(s1_d),
    .s2(s2_d),
    .s3(s3_d),
    .s4(s4_d),
    .s5(s5_d),
    .s6(s6_d),
    .s7(s7_d),
    .s8(s8_d)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
      s5_q <= '0;
      s6_q <= '0;
      s7_q <= '0;
      s8_q <= 1'b0;
    end else if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
      s5_q <= s5_d;
      s6_q <= s6_d;
      s7_q <= s7_d;
      s8_q <= s8_d;
    end

  assign s1 = s1_q;
  assign s2 = s2_q;
  assign s3 = s3_q;
  assign s4 = s4_q;
  assign s5 = s5_q;
  assign s6 = s6_q;
  assign s7 = s7_q;
  assign s8 = s8_q;
endmodule

// File: tb/tb_portas_logicas.sv
// tb_portas_logicas: directed vectors with a queue-based scoreboard and decoupled monitor
module tb_portas_logicas;
  logic       clk = 1'b0;
  logic       run = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] a = '0, b = '0;
  logic [2:0] s1, s2, s3, s4, s5, s6, s7;
  logic       s8;
  int         errors = 0, checks = 0;

  typedef struct packed {
    logic [2:0] a, b;
    logic [21:0] exp;
  } vec_t;

  logic [21:0] exp_q[$];
  vec_t        vecs[8];

  portas_logicas #(.WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .s7(s7), .s8(s8)
  );

  always #5 clk = run ? ~clk : clk;

  function automatic logic [21:0] outs();
    return {s1, s2, s3, s4, s5, s6, s7, s8};
  endfunction

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got s1..s8=%b_%b_%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b_%b_%b",
               name, got[21:19], got[18:16], got[15:13], got[12:10], got[9:7], got[6:4], got[3:1], got[0],
               exp[21:19], exp[18:16], exp[15:13], exp[12:10], exp[9:7], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  // Monitor: items pending at a rising edge were captured by it; compare at the next falling edge
  initial begin
    int pend;
    forever begin
      @(posedge clk);
      pend = exp_q.size();
      @(negedge clk);
      if (pend > 0 && exp_q.size() > 0) check("scoreboard", outs(), exp_q.pop_front());
    end
  end

  task automatic drive(input logic e, input logic [2:0] va, input logic [2:0] vb, input logic [21:0] exp);
    @(negedge clk);
    en = e;
    a  = va;
    b  = vb;
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unconsumed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  localparam logic [21:0] ZERO = '0;
  localparam logic [21:0] HOLD = {3'b100, 3'b111, 3'b011, 3'b000, 3'b011, 3'b100, 3'b010, 1'b0};

  initial begin
    vecs[0] = '{3'b000, 3'b000, {3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 3'b111, 3'b111, 1'b1}};
    vecs[1] = '{3'b010, 3'b011, {3'b010, 3'b011, 3'b101, 3'b100, 3'b001, 3'b110, 3'b101, 1'b0}};
    vecs[2] = '{3'b110, 3'b101, {3'b100, 3'b111, 3'b011, 3'b000, 3'b011, 3'b100, 3'b001, 1'b0}};
    vecs[3] = '{3'b111, 3'b111, {3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1}};
    vecs[4] = '{3'b001, 3'b100, {3'b000, 3'b101, 3'b111, 3'b010, 3'b101, 3'b010, 3'b110, 1'b0}};
    vecs[5] = '{3'b011, 3'b011, {3'b011, 3'b011, 3'b100, 3'b100, 3'b000, 3'b111, 3'b100, 1'b1}};
    vecs[6] = '{3'b011, 3'b111, {3'b011, 3'b111, 3'b100, 3'b000, 3'b100, 3'b011, 3'b100, 1'b0}};
    vecs[7] = '{3'b101, 3'b110, HOLD};

    // Reset with no clock edge at all
    a = 3'b111;
    b = 3'b111;
    en = 1'b1;
    #2 check("reset_no_clk", outs(), ZERO);
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_with_clk_en", outs(), ZERO);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 3'b111, 3'b111, ZERO);
    foreach (vecs[i]) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
    repeat (3) drive(1'b0, 3'b111, 3'b000, HOLD);
    drain();

    // Asynchronous reset mid-operation, away from any edge
    #2 rst_n = 1'b0;
    #1 check("reset_async_mid", outs(), ZERO);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 3'b010, 3'b011, ZERO);
    drive(1'b1, vecs[1].a, vecs[1].b, vecs[1].exp);
    drive(1'b1, vecs[3].a, vecs[3].b, vecs[3].exp);
    drive(1'b0, 3'b000, 3'b000, vecs[3].exp);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/portas_logicas.md
PORTAS_LOGICAS -- requirements
Module: portas_logicas

Interface
REQ-001 Parameter: WIDTH, default 3, bit width of operands a, b and of outputs s1..s7.
REQ-002 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port: en, input, 1, capture enable; when high, outputs update on the next rising clk edge.
REQ-005 Port: a, input, WIDTH, operand A.
REQ-006 Port: b, input, WIDTH, operand B.
REQ-007 Port: s1, output, WIDTH, bitwise AND (a & b).
REQ-008 Port: s2, output, WIDTH, bitwise OR (a | b).
REQ-009 Port: s3, output, WIDTH, bitwise NAND ~(a & b).
REQ-010 Port: s4, output, WIDTH, bitwise NOR ~(a | b).
REQ-011 Port: s5, output, WIDTH, bitwise XOR (a ^ b).
REQ-012 Port: s6, output, WIDTH, bitwise XNOR ~(a ^ b).
REQ-013 Port: s7, output, WIDTH, bitwise NOT of a (~a).
REQ-014 Port: s8, output, 1, equality flag; 1 when a == b, else 0.

Function
REQ-015 All outputs SHALL be registered; latency is exactly one clk cycle from the a/b values sampled with en=1.
REQ-016 When en=0, s1..s8 SHALL hold their previous values.
REQ-017 Every output bit i of s1..s6 SHALL depend only on a[i] and b[i]; s7[i] SHALL depend only on a[i]; there is no carry or cross-bit coupling.
REQ-018 s8 SHALL compare all WIDTH bits; s8 is 1 only when every bit of a matches b.
REQ-019 No saturation or wrap-around applies; all results are exactly WIDTH bits, except s8, which is 1 bit.
REQ-020 Outputs SHALL be free of X whenever a and b are known and at least one capture has occurred since reset.

Reset
REQ-021 While rst_n=0, s1..s7 SHALL be all-zero and s8 SHALL be 0, independent of clk.
REQ-022 Reset assertion mid-operation SHALL clear the outputs immediately.
REQ-023 On deassertion, the first capture SHALL occur on the first rising clk edge where en=1.

Structure
REQ-024 A shared package portas_logicas_pkg SHALL hold the WIDTH default constant.
REQ-025 A sub-module portas_logicas_core SHALL compute s1..s8 combinationally from a and b.
REQ-026 The top level SHALL contain only that core plus the output register bank with enable and async reset.

Verification
REQ-027 Reset: rst_n=0 with a=111, b=111 -> s1..s7=000, s8=0 without any clk edge.
REQ-028 Equal-zero case: a=000, b=000, en=1, one edge -> s1=000, s2=000, s3=111, s4=111, s5=000, s6=111, s7=111, s8=1.
REQ-029 Mixed case: a=010, b=011 -> s1=010, s2=011, s3=101, s4=100, s5=001, s6=110, s7=101, s8=0.
REQ-030 Mixed case: a=110, b=101 -> s1=100, s2=111, s3=011, s4=000, s5=011, s6=100, s7=001, s8=0.
REQ-031 Equal-ones case: a=111, b=111 -> s1=111, s2=111, s3=000, s4=000, s5=000, s6=111, s7=000, s8=1.
REQ-032 Hold: after capturing a=101, b=110, drive en=0 and a=111, b=000 for 3 cycles -> outputs remain s1=100, s2=111, s3=011, s4=000, s5=011, s6=100, s7=010, s8=0.
